// File: rtl/mem_pkg.sv
// Shared memory-path definitions: store/load size encodings, the store
// sequencer state enum and the request legality check.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MRG,
    WR,
    ERR
  } st_e;

  // Reserved size, or a word/half whose byte offset breaks its natural alignment.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] offset);
    return (size == 2'b11) ||
           ((size == SZ_WORD) && (offset != 2'b00)) ||
           ((size == SZ_HALF) && offset[0]);
  endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// Bundle of the datapath store request and the data-RAM port of the store path.
interface store_merge_unit_if #(
  parameter int ADDR_W = 10
);

  logic              req;
  logic [1:0]        size;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;

  modport master (
    output req, size, addr, wdata, mem_rdata,
    input  ready, done, err, mem_addr, mem_re, mem_we, mem_wdata, mem_be
  );

  modport slave (
    input  req, size, addr, wdata, mem_rdata,
    output ready, done, err, mem_addr, mem_re, mem_we, mem_wdata, mem_be
  );

endinterface

// File: rtl/store_lane_merge.sv
// Little-endian lane merge: replaces the selected byte/half lanes of the
// word read from RAM with the store data and reports the written lanes.
module store_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged,
  output logic [3:0]  be
);

  always_comb begin
    merged = rdata;
    be     = 4'b0000;
    case (size)
      SZ_WORD: begin
        merged = wdata;
        be     = 4'b1111;
      end
      SZ_HALF: begin
        if (offset[1]) begin
          merged[31:16] = wdata[15:0];
          be            = 4'b1100;
        end else begin
          merged[15:0] = wdata[15:0];
          be           = 4'b0011;
        end
      end
      SZ_BYTE: begin
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
        be                            = 4'b0001 << offset;
      end
      default: begin
        merged = rdata;
        be     = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store-side data RAM sequencer: SW writes directly, SH/SB read-modify-write
// so untouched bytes survive; ready low stalls the core while busy.
module store_merge_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input logic               clk,
  input logic               rst_n,
  store_merge_unit_if.slave bus
);

  st_e               state;
  logic [1:0]        size_q;
  logic [1:0]        offset_q;
  logic [15:0]       wdata_q;
  logic              ready_q;
  logic              done_q;
  logic              err_q;
  logic              mem_re_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       merged;
  logic [3:0]        merged_be;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus.addr[31:ADDR_W+2];

  // The merge only ever sees the latched request, never the live bus.
  store_lane_merge u_merge (
    .rdata  (bus.mem_rdata),
    .wdata  ({16'h0000, wdata_q}),
    .size   (size_q),
    .offset (offset_q),
    .merged (merged),
    .be     (merged_be)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      size_q      <= SZ_BYTE;
      offset_q    <= 2'b00;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            ready_q    <= 1'b0;
            mem_addr_q <= bus.addr[ADDR_W+1:2];
            size_q     <= bus.size;
            offset_q   <= bus.addr[1:0];
            wdata_q    <= bus.wdata[15:0];
            if (req_illegal(bus.size, bus.addr[1:0])) begin
              err_q <= 1'b1;
              state <= ERR;
            end else if (bus.size == SZ_WORD) begin
              // Full word needs no read: present the write in the next cycle.
              mem_wdata_q <= bus.wdata;
              mem_be_q    <= 4'b1111;
              mem_we_q    <= 1'b1;
              done_q      <= 1'b1;
              state       <= WR;
            end else begin
              mem_re_q <= 1'b1;
              state    <= RD;
            end
          end
        end
        RD: begin
          state <= MRG;
        end
        MRG: begin
          mem_wdata_q <= merged;
          mem_be_q    <= merged_be;
          mem_we_q    <= 1'b1;
          done_q      <= 1'b1;
          state       <= WR;
        end
        WR: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        ERR: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit with a byte-enabled RAM model and
// hand-computed expected words, strobes and lane enables.
module tb_store_merge_unit;
  import mem_pkg::*;

  localparam int ADDR_W = 10;

  logic clk;
  logic rst_n;

  store_merge_unit_if #(.ADDR_W(ADDR_W)) bus ();

  store_merge_unit #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic              poke_en;
  logic [ADDR_W-1:0] poke_addr;
  logic [31:0]       poke_data;
  int                re_cnt;
  int                we_cnt;
  int                done_cnt;
  int                err_cnt;
  int                overlap_cnt;
  int                cmp_cnt;
  int                mis_cnt;

  // RAM model: registered read, byte-enabled write, plus a bench preload port.
  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
    if (bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (bus.mem_re) re_cnt <= re_cnt + 1;
    if (bus.mem_we) we_cnt <= we_cnt + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.err) err_cnt <= err_cnt + 1;
    if (bus.mem_re && bus.mem_we) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      mis_cnt++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] d);
    bus.req   = r;
    bus.size  = sz;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  task automatic pokeRam(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".ready"},     {31'd0, bus.ready},  32'd1);
    checkOutput({tag, ".done"},      {31'd0, bus.done},   32'd0);
    checkOutput({tag, ".err"},       {31'd0, bus.err},    32'd0);
    checkOutput({tag, ".mem_re"},    {31'd0, bus.mem_re}, 32'd0);
    checkOutput({tag, ".mem_we"},    {31'd0, bus.mem_we}, 32'd0);
    checkOutput({tag, ".mem_addr"},  {22'd0, bus.mem_addr}, 32'd0);
    checkOutput({tag, ".mem_wdata"}, bus.mem_wdata,       32'd0);
    checkOutput({tag, ".mem_be"},    {28'd0, bus.mem_be}, 32'd0);
  endtask

  // Illegal request: err pulse in cycle 1, idle again in cycle 2, RAM untouched.
  task automatic errCase(input string tag, input logic [1:0] sz, input logic [31:0] a);
    int re0, we0;
    re0 = re_cnt;
    we0 = we_cnt;
    applyStimulus(1'b1, sz, a, 32'h1234_5678);
    tick();
    applyStimulus(1'b0, SZ_BYTE, 32'd0, 32'd0);
    checkOutput({tag, ".err_c1"},   {31'd0, bus.err},    32'd1);
    checkOutput({tag, ".done_c1"},  {31'd0, bus.done},   32'd0);
    checkOutput({tag, ".mem_re_c1"},{31'd0, bus.mem_re}, 32'd0);
    checkOutput({tag, ".mem_we_c1"},{31'd0, bus.mem_we}, 32'd0);
    tick();
    checkOutput({tag, ".ready_c2"}, {31'd0, bus.ready},  32'd1);
    checkOutput({tag, ".err_c2"},   {31'd0, bus.err},    32'd0);
    checkOutput({tag, ".re_count"}, re_cnt - re0, 32'd0);
    checkOutput({tag, ".we_count"}, we_cnt - we0, 32'd0);
  endtask

  initial begin
    int re0, we0, done0;
    cmp_cnt     = 0;
    mis_cnt     = 0;
    re_cnt      = 0;
    we_cnt      = 0;
    done_cnt    = 0;
    err_cnt     = 0;
    overlap_cnt = 0;
    poke_en     = 1'b0;
    poke_addr   = '0;
    poke_data   = '0;
    bus.mem_rdata = 32'd0;
    applyStimulus(1'b0, SZ_BYTE, 32'd0, 32'd0);
    rst_n = 1'b0;
    repeat (3) tick();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tick();
    pokeRam(10'd4, 32'h1122_3344);

    $display("[TB] SW 0x10");
    re0 = re_cnt;
    applyStimulus(1'b1, SZ_WORD, 32'h0000_0010, 32'hDEAD_BEEF);
    tick();
    applyStimulus(1'b0, SZ_BYTE, 32'd0, 32'd0);
    checkOutput("sw.mem_we_c1",    {31'd0, bus.mem_we}, 32'd1);
    checkOutput("sw.done_c1",      {31'd0, bus.done},   32'd1);
    checkOutput("sw.ready_c1",     {31'd0, bus.ready},  32'd0);
    checkOutput("sw.mem_addr_c1",  {22'd0, bus.mem_addr}, 32'd4);
    checkOutput("sw.mem_wdata_c1", bus.mem_wdata,       32'hDEAD_BEEF);
    checkOutput("sw.mem_be_c1",    {28'd0, bus.mem_be}, 32'hF);
    tick();
    checkOutput("sw.ready_c2",     {31'd0, bus.ready},  32'd1);
    checkOutput("sw.mem_we_c2",    {31'd0, bus.mem_we}, 32'd0);
    checkOutput("sw.re_count",     re_cnt - re0,        32'd0);
    checkOutput("sw.ram4",         ram[4],              32'hDEAD_BEEF);

    $display("[TB] SB 0x12");
    pokeRam(10'd4, 32'h1122_3344);
    applyStimulus(1'b1, SZ_BYTE, 32'h0000_0012, 32'h0000_00AB);
    tick();
    applyStimulus(1'b0, SZ_BYTE, 32'd0, 32'd0);
    checkOutput("sb.mem_re_c1",    {31'd0, bus.mem_re}, 32'd1);
    checkOutput("sb.mem_addr_c1",  {22'd0, bus.mem_addr}, 32'd4);
    checkOutput("sb.mem_we_c1",    {31'd0, bus.mem_we}, 32'd0);
    tick();
    checkOutput("sb.mem_re_c2",    {31'd0, bus.mem_re}, 32'd0);
    checkOutput("sb.mem_we_c2",    {31'd0, bus.mem_we}, 32'd0);
    tick();
    checkOutput("sb.mem_we_c3",    {31'd0, bus.mem_we}, 32'd1);
    checkOutput("sb.done_c3",      {31'd0, bus.done},   32'd1);
    checkOutput("sb.mem_addr_c3",  {22'd0, bus.mem_addr}, 32'd4);
    checkOutput("sb.mem_wdata_c3", bus.mem_wdata,       32'h11AB_3344);
    checkOutput("sb.mem_be_c3",    {28'd0, bus.mem_be}, 32'b0100);
    tick();
    checkOutput("sb.ready_c4",     {31'd0, bus.ready},  32'd1);
    checkOutput("sb.ram4",         ram[4],              32'h11AB_3344);

    $display("[TB] SH 0x12");
    pokeRam(10'd4, 32'h1122_3344);
    applyStimulus(1'b1, SZ_HALF, 32'h0000_0012, 32'hFFFF_CAFE);
    tick();
    applyStimulus(1'b0, SZ_BYTE, 32'd0, 32'd0);
    checkOutput("sh.mem_re_c1",    {31'd0, bus.mem_re}, 32'd1);
    tick();
    tick();
    checkOutput("sh.mem_we_c3",    {31'd0, bus.mem_we}, 32'd1);
    checkOutput("sh.mem_wdata_c3", bus.mem_wdata,       32'hCAFE_3344);
    checkOutput("sh.mem_be_c3",    {28'd0, bus.mem_be}, 32'b1100);
    tick();
    checkOutput("sh.ready_c4",     {31'd0, bus.ready},  32'd1);

    $display("[TB] illegal requests");
    errCase("sh_0x13",  SZ_HALF, 32'h0000_0013);
    errCase("sw_0x11",  SZ_WORD, 32'h0000_0011);
    errCase("size_11",  2'b11,   32'h0000_0010);

    $display("[TB] back-to-back SB");
    pokeRam(10'd4, 32'h1122_3344);
    done0 = done_cnt;
    applyStimulus(1'b1, SZ_BYTE, 32'h0000_0010, 32'h0000_00AB);
    tick();
    applyStimulus(1'b1, SZ_BYTE, 32'h0000_0011, 32'h0000_00CD);
    tick();
    tick();
    checkOutput("b2b.wdata1_c3",   bus.mem_wdata,       32'h1122_33AB);
    checkOutput("b2b.be1_c3",      {28'd0, bus.mem_be}, 32'b0001);
    tick();
    checkOutput("b2b.ready_c4",    {31'd0, bus.ready},  32'd1);
    tick();
    applyStimulus(1'b0, SZ_BYTE, 32'd0, 32'd0);
    checkOutput("b2b.mem_re_c5",   {31'd0, bus.mem_re}, 32'd1);
    checkOutput("b2b.ready_c5",    {31'd0, bus.ready},  32'd0);
    tick();
    tick();
    checkOutput("b2b.mem_we_c7",   {31'd0, bus.mem_we}, 32'd1);
    checkOutput("b2b.wdata2_c7",   bus.mem_wdata,       32'h1122_CDAB);
    checkOutput("b2b.be2_c7",      {28'd0, bus.mem_be}, 32'b0010);
    tick();
    checkOutput("b2b.ram4",        ram[4],              32'h1122_CDAB);
    checkOutput("b2b.done_count",  done_cnt - done0,    32'd2);

    $display("[TB] reset during MRG");
    pokeRam(10'd4, 32'h1122_3344);
    we0 = we_cnt;
    applyStimulus(1'b1, SZ_BYTE, 32'h0000_0013, 32'h0000_0055);
    tick();
    applyStimulus(1'b0, SZ_BYTE, 32'd0, 32'd0);
    tick();
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rst_mrg");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("rst_mrg.we_count", we_cnt - we0, 32'd0);
    checkOutput("rst_mrg.ram4",     ram[4],       32'h1122_3344);
    applyStimulus(1'b1, SZ_WORD, 32'h0000_0014, 32'h0102_0304);
    tick();
    applyStimulus(1'b0, SZ_BYTE, 32'd0, 32'd0);
    checkOutput("post_rst.mem_we",   {31'd0, bus.mem_we}, 32'd1);
    checkOutput("post_rst.mem_addr", {22'd0, bus.mem_addr}, 32'd5);
    checkOutput("post_rst.done",     {31'd0, bus.done},   32'd1);
    tick();
    checkOutput("post_rst.ram5",     ram[5],              32'h0102_0304);
    checkOutput("re_we_overlap",     overlap_cnt,         32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Store-side memory path of the single-cycle MIPS datapath, and the write counterpart of the load extraction path that feeds register-file Din. It takes SW/SH/SB requests from the datapath and writes the data RAM. SW is written directly. SH and SB use a read-modify-write sequence so the untouched bytes of the word are preserved. It drives `ready` low while a sequence is in flight so the PC-enable logic can stall the core.

## Interface

**Parameters**

- `ADDR_W`, default 10: word-address width of the data RAM.

**Ports**

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req`, in, 1: store request, sampled only when `ready`=1.
- `size`, in, 2: store size; 2'b10 word, 2'b01 half, 2'b00 byte, 2'b11 reserved.
- `addr`, in, 32: byte address (ALU Result1).
- `wdata`, in, 32: store data (R2 read port). Byte uses [7:0]; half uses [15:0].
- `ready`, out, 1: 1 in IDLE; 0 while a store is in flight.
- `done`, out, 1: one-cycle pulse in the cycle the RAM write is issued.
- `err`, out, 1: one-cycle pulse on a misaligned or reserved-size request; no write is performed.
- `mem_addr`, out, ADDR_W: word address, equal to `addr[ADDR_W+1:2]`, latched at accept.
- `mem_re`, out, 1: RAM read strobe.
- `mem_rdata`, in, 32: RAM read data, valid the cycle after `mem_re`.
- `mem_we`, out, 1: RAM write strobe.
- `mem_wdata`, out, 32: merged word to write.
- `mem_be`, out, 4: byte enables of the written lanes, for debug and for byte-enabled RAMs.

## Operation

**Lane mapping (little-endian)**

- Byte at `addr[1:0]`=k occupies bits [8k+7:8k].
- Half at `addr[1]`=h occupies bits [16h+15:16h].
- Merge: `mem_wdata` = `mem_rdata` with the selected lanes replaced by the `wdata` low byte or low half.
- `mem_be` values: word 4'b1111; half 4'b0011 or 4'b1100; byte is one-hot `1<<k`.

**Alignment check** (applied at accept)

- Word requires `addr[1:0]`=0.
- Half requires `addr[0]`=0.
- `size`=11 is an error.
- On a violation: pulse `err`, go straight back to IDLE, no `mem_re` and no `mem_we`.

**State machine**

- IDLE: `ready`=1. On `req`, latch `addr`, `wdata`, `size`.
  - Word → WR.
  - Half/byte → RD.
  - Error → ERR.
- RD: `mem_re`=1 with the latched `mem_addr` → MRG.
- MRG: capture `mem_rdata` and form the merged word in a register → WR.
- WR: `mem_we`=1, `done`=1, `mem_wdata` and `mem_be` valid → IDLE.
- ERR: `err`=1 → IDLE.

**Rules**

- `req` is ignored while `ready`=0. No queueing.
- `mem_re` and `mem_we` are never high in the same cycle.
- All outputs are registered or decoded from state only. No combinational path from `req` to `mem_*`.

## Timing

- Reset values: state IDLE, `ready`=1; `done`, `err`, `mem_re`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `mem_be` = 0.
- Word store: `req` accepted in cycle 0; `mem_we` and `done` in cycle 1; `ready` back to 1 in cycle 2.
- Half/byte store: `req` in cycle 0; `mem_re` in cycle 1; `mem_rdata` sampled in cycle 2; `mem_we` and `done` in cycle 3; `ready` in cycle 4.
- Error: `err` in cycle 1; `ready` in cycle 2.
- Back-to-back: a `req` held high is re-accepted in the first cycle `ready`=1. Each accept produces exactly one `done` or `err`.
- Reset asserted mid-sequence aborts immediately. No `mem_we` follows, even if reset is released in the cycle that would have been WR.
- `mem_addr` stays stable from RD through WR.

## Structure

- Shared package `mem_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - state enum `st_e` {IDLE, RD, MRG, WR, ERR}.
- The load-side Din extraction reuses the same size encodings.
- One natural combinational sub-module: `store_lane_merge`.
  - Inputs: `rdata`, `wdata`, `size`, `offset[1:0]`.
  - Outputs: `merged`, `be`.
  - Instantiated once and driven from the latched request.

## Test plan

- SW with `addr`=0x0000_0010, `wdata`=0xDEAD_BEEF → cycle 1: `mem_we`=1, `mem_addr`=4, `mem_wdata`=0xDEADBEEF, `mem_be`=1111, `done`=1; `mem_re` never asserted.
- SB with RAM[4]=0x1122_3344, `addr`=0x12, `wdata`=0x0000_00AB → `mem_re` in cycle 1; cycle 3: `mem_wdata`=0x11AB_3344, `mem_be`=0100.
- SH with RAM[4]=0x1122_3344, `addr`=0x12, `wdata`=0xFFFF_CAFE → cycle 3: `mem_wdata`=0xCAFE_3344, `mem_be`=1100.
- Misalignment and reserved size:
  - SH at `addr`=0x13 → `err` in cycle 1, no `mem_re`/`mem_we`, `ready`=1 in cycle 2.
  - SW at 0x11 → same response.
  - `size`=11 → same response.
- `req` held high for two SB stores at 0x10 then 0x11 → second accepted in cycle 4; second `mem_re` in cycle 5. The second merge uses the RAM content left by the first write: RAM[4] goes 0x1122_3344 → 0x1122_33AB → 0x1122_CDAB for `wdata` 0xAB then 0xCD.
- `rst_n` pulsed low during MRG of an SB → all outputs return to reset values asynchronously, no `mem_we` ever issued, RAM unchanged, next SW completes normally.
